gf163_divider: RTL

GF163_DIVIDER -- requirements
Module: gf163_divider

---
 rtl/gf163_divider_if.sv | 12 +
 rtl/gf163_divider.sv | 126 ++++++++++++
 2 files changed

// File: rtl/gf163_divider_if.sv
// rtl/gf163_divider_if.sv - request/result bundle for the GF(2^163) divider
interface gf163_divider_if;
  logic         start;
  logic [162:0] A;
  logic [162:0] B;
  logic [162:0] Z;
  logic         done;
  logic         err;

  modport master (output start, A, B, input Z, done, err);
  modport slave  (input start, A, B, output Z, done, err);
endinterface

// File: rtl/gf163_divider.sv
// rtl/gf163_divider.sv - GF(2^163) division Z = A * B^-1 mod f by binary Euclid
module gf163_divider #(
  parameter int MAXIT = 652
) (
`ifdef USE_POWER_PINS
  inout wire vccd2,
  inout wire vssd2,
`endif
  input logic            clk,
  input logic            rst,
  gf163_divider_if.slave bus
);

  localparam logic [163:0] F  = {1'b1, 163'hC9};
  // (f >> 1) restricted to bits 161:0, used when halving an odd X/Y
  localparam logic [161:0] FH = 162'h64;
  localparam int           CW = $clog2(MAXIT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, ITER, ST_DONE} state_t;

  state_t         state, state_n;
  logic [163:0]   u, v, u_n, v_n;
  logic [162:0]   x, y, z, x_n, y_n, z_n;
  logic [162:0]   x_half, y_half;
  logic [CW-1:0]  cnt, cnt_n;
  logic           err, err_n;
  logic           armed, armed_n;

  assign x_half = x[0] ? {1'b1, x[162:1] ^ FH} : {1'b0, x[162:1]};
  assign y_half = y[0] ? {1'b1, y[162:1] ^ FH} : {1'b0, y[162:1]};

  always_comb begin
    state_n = state;
    u_n     = u;
    v_n     = v;
    x_n     = x;
    y_n     = y;
    z_n     = z;
    cnt_n   = cnt;
    err_n   = err;
    // a low start at any edge re-arms; only a fresh rising request may load
    armed_n = armed | ~bus.start;
    case (state)
      IDLE: begin
        if (bus.start && armed) begin
          state_n = LOAD;
          armed_n = 1'b0;
        end
      end
      LOAD: begin
        u_n   = {1'b0, bus.B};
        v_n   = F;
        x_n   = bus.A;
        y_n   = '0;
        cnt_n = '0;
        err_n = 1'b0;
        if (bus.B == '0) begin
          err_n   = 1'b1;
          z_n     = '0;
          state_n = ST_DONE;
        end else begin
          state_n = ITER;
        end
      end
      ITER: begin
        cnt_n = cnt + 1'b1;
        if (!bus.start) begin
          state_n = IDLE;
        end else if (u == 164'd1) begin
          z_n     = x;
          state_n = ST_DONE;
        end else if (v == 164'd1) begin
          z_n     = y;
          state_n = ST_DONE;
        end else if (cnt == CW'(MAXIT - 1)) begin
          err_n   = 1'b1;
          z_n     = '0;
          state_n = ST_DONE;
        end else if (!u[0]) begin
          u_n = u >> 1;
          x_n = x_half;
        end else if (!v[0]) begin
          v_n = v >> 1;
          y_n = y_half;
        end else if (u > v) begin
          u_n = u ^ v;
          x_n = x ^ y;
        end else begin
          v_n = v ^ u;
          y_n = y ^ x;
        end
      end
      ST_DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      u     <= '0;
      v     <= '0;
      x     <= '0;
      y     <= '0;
      z     <= '0;
      cnt   <= '0;
      err   <= 1'b0;
      armed <= 1'b0;
    end else begin
      state <= state_n;
      u     <= u_n;
      v     <= v_n;
      x     <= x_n;
      y     <= y_n;
      z     <= z_n;
      cnt   <= cnt_n;
      err   <= err_n;
      armed <= armed_n;
    end
  end

  assign bus.Z    = z;
  assign bus.err  = err;
  assign bus.done = (state == ST_DONE);

endmodule
